// File: rtl/full_adder.sv
// full_adder: registered, width-parameterised ripple-carry adder.
//
// Computes {cout, sum} = a + b + cin through an explicit chain of 1-bit
// full-adder cells and registers the result one clock after the operands
// are sampled with in_valid high.
//
// Optional feature (macro FULL_ADDER_OVF_EN): adds the registered ovf output,
// the two's-complement signed overflow flag (carry into MSB ^ carry out).
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        synchronous active-high reset
//   in_valid   a/b/cin are valid this cycle
//   a, b       WIDTH-bit unsigned addends
//   cin        carry into bit 0
//   out_valid  sum/cout/zero (and ovf) hold a fresh result
//   sum        registered (a + b + cin) mod 2^WIDTH
//   cout       registered carry out of bit WIDTH-1
//   zero       registered flag, high when the registered sum is all zeros
//   ovf        (FULL_ADDER_OVF_EN only) registered signed overflow
module full_adder #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             zero
`ifdef FULL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic [WIDTH-1:0] s;
  logic             c_top;

  // Each cell keeps its own carry nets so the ripple chain is a set of
  // distinct signals rather than a self-referencing vector.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic ci;
    logic co;
    if (i == 0) begin : g_first
      assign ci = cin;
    end else begin : g_rest
      assign ci = g_cell[i-1].co;
    end
    assign s[i] = a[i] ^ b[i] ^ ci;
    assign co   = (a[i] & b[i]) | (a[i] & ci) | (b[i] & ci);
  end

  assign c_top = g_cell[WIDTH-1].co;

`ifdef FULL_ADDER_OVF_EN
  logic ovf_c;
  // Carry into the MSB; for WIDTH=1 this is cin itself.
  assign ovf_c = c_top ^ g_cell[WIDTH-1].ci;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      zero      <= 1'b0;
`ifdef FULL_ADDER_OVF_EN
      ovf       <= 1'b0;
`endif
    end else if (in_valid) begin
      out_valid <= 1'b1;
      sum       <= s;
      cout      <= c_top;
      zero      <= (s == '0);
`ifdef FULL_ADDER_OVF_EN
      ovf       <= ovf_c;
`endif
    end else begin
      // Idle: result registers hold, only the valid flag drops.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Directed self-checking bench for full_adder at WIDTH = 1, 4 and 8.
module tb_full_adder;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  // WIDTH=1 instance
  logic       iv1, a1, b1, ci1, ov1, s1, co1, z1;
  // WIDTH=4 instance
  logic       iv4, ci4, ov4, co4, z4;
  logic [3:0] a4, b4, s4;
  // WIDTH=8 instance
  logic       iv8, ci8, ov8, co8, z8;
  logic [7:0] a8, b8, s8;
`ifdef FULL_ADDER_OVF_EN
  logic       f1, f4, f8;
`endif

  full_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .a(a1), .b(b1), .cin(ci1),
    .out_valid(ov1), .sum(s1), .cout(co1), .zero(z1)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(f1)
`endif
  );

  full_adder #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .a(a4), .b(b4), .cin(ci4),
    .out_valid(ov4), .sum(s4), .cout(co4), .zero(z4)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(f4)
`endif
  );

  full_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .a(a8), .b(b8), .cin(ci8),
    .out_valid(ov8), .sum(s8), .cout(co8), .zero(z8)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(f8)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({ov1, s1, co1, z1} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_w1: got ov/s/co/z=%b required 0000", {ov1, s1, co1, z1});
    end
    total++;
    if ({ov8, s8, co8, z8} !== 11'b0) begin
      bad++;
      $display("FAIL reset_w8: got ov=%b s=%h co=%b z=%b required all 0", ov8, s8, co8, z8);
    end
    // Load 1+1+1, then reset with in_valid still high.
    rst = 1'b0; iv1 = 1'b1; a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1;
    tick();
    total++;
    if ({ov1, s1, co1, z1} !== 4'b1110) begin
      bad++;
      $display("FAIL load_111: got ov/s/co/z=%b required 1110", {ov1, s1, co1, z1});
    end
    rst = 1'b1;
    tick();
    total++;
    if ({ov1, s1, co1, z1} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_priority: got ov/s/co/z=%b required 0000", {ov1, s1, co1, z1});
    end
    rst = 1'b0; iv1 = 1'b0;
    tick();
    total++;
    if (ov1 !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_idle: got out_valid=%b required 0", ov1);
    end
    iv1 = 1'b1; a1 = 1'b1; b1 = 1'b0; ci1 = 1'b0;
    tick();
    iv1 = 1'b0;
    total++;
    if ({ov1, s1, co1, z1} !== 4'b1100) begin
      bad++;
      $display("FAIL first_after_reset: got ov/s/co/z=%b required 1100", {ov1, s1, co1, z1});
    end
  endtask

  task automatic test_truth_table();
    logic [7:0] exp_s;
    logic [7:0] exp_c;
    exp_s = 8'b1001_0110;
    exp_c = 8'b1110_1000;
    for (int v = 0; v < 8; v++) begin
      iv1 = 1'b1; a1 = v[2]; b1 = v[1]; ci1 = v[0];
      tick();
      total++;
      if (ov1 !== 1'b1 || s1 !== exp_s[v] || co1 !== exp_c[v] || z1 !== ~exp_s[v]) begin
        bad++;
        $display("FAIL truth_%0d: got ov=%b s=%b co=%b z=%b required 1 %b %b %b",
                 v, ov1, s1, co1, z1, exp_s[v], exp_c[v], ~exp_s[v]);
      end
    end
    iv1 = 1'b0;
    tick();
  endtask

  task automatic test_idle_hold();
    iv8 = 1'b1; a8 = 8'h12; b8 = 8'h34; ci8 = 1'b0;
    tick();
    total++;
    if (ov8 !== 1'b1 || s8 !== 8'h46 || co8 !== 1'b0 || z8 !== 1'b0) begin
      bad++;
      $display("FAIL idle_load: got ov=%b s=%h co=%b z=%b required 1 46 0 0", ov8, s8, co8, z8);
    end
    // Garbage operands while idle must not leak into the outputs.
    iv8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (ov8 !== 1'b0 || s8 !== 8'h46 || co8 !== 1'b0 || z8 !== 1'b0) begin
        bad++;
        $display("FAIL idle_hold_%0d: got ov=%b s=%h co=%b z=%b required 0 46 0 0",
                 i, ov8, s8, co8, z8);
      end
    end
  endtask

  task automatic test_carry_wrap();
    iv8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; ci8 = 1'b1;
    tick();
    a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;
    total++;
    if (ov8 !== 1'b1 || s8 !== 8'h00 || co8 !== 1'b1 || z8 !== 1'b1) begin
      bad++;
      $display("FAIL wrap: got ov=%b s=%h co=%b z=%b required 1 00 1 1", ov8, s8, co8, z8);
    end
    tick();
    iv8 = 1'b0;
    total++;
    if (ov8 !== 1'b1 || s8 !== 8'hFF || co8 !== 1'b1 || z8 !== 1'b0) begin
      bad++;
      $display("FAIL max: got ov=%b s=%h co=%b z=%b required 1 ff 1 0", ov8, s8, co8, z8);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] va [4];
    logic [3:0] vb [4];
    logic       vc [4];
    logic [3:0] es [4];
    logic       ec [4];
    logic       ez [4];
    va = '{4'd3, 4'd15, 4'd7, 4'd0};
    vb = '{4'd4, 4'd1,  4'd8, 4'd0};
    vc = '{1'b0, 1'b0,  1'b1, 1'b0};
    es = '{4'd7, 4'd0,  4'd0, 4'd0};
    ec = '{1'b0, 1'b1,  1'b1, 1'b0};
    ez = '{1'b0, 1'b1,  1'b1, 1'b1};
    iv4 = 1'b1; a4 = va[0]; b4 = vb[0]; ci4 = vc[0];
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i < 3) begin
        a4 = va[i+1]; b4 = vb[i+1]; ci4 = vc[i+1];
      end else begin
        iv4 = 1'b0;
      end
      total++;
      if (ov4 !== 1'b1 || s4 !== es[i] || co4 !== ec[i] || z4 !== ez[i]) begin
        bad++;
        $display("FAIL b2b_%0d: got ov=%b s=%0d co=%b z=%b required 1 %0d %b %b",
                 i, ov4, s4, co4, z4, es[i], ec[i], ez[i]);
      end
    end
    tick();
    total++;
    if (ov4 !== 1'b0) begin
      bad++;
      $display("FAIL b2b_drain: got out_valid=%b required 0", ov4);
    end
  endtask

`ifdef FULL_ADDER_OVF_EN
  task automatic test_ovf();
    iv8 = 1'b1; a8 = 8'h7F; b8 = 8'h01; ci8 = 1'b0;
    tick();
    total++;
    if (s8 !== 8'h80 || co8 !== 1'b0 || f8 !== 1'b1) begin
      bad++;
      $display("FAIL ovf_pos: got s=%h co=%b ovf=%b required 80 0 1", s8, co8, f8);
    end
    a8 = 8'h80; b8 = 8'h80;
    tick();
    total++;
    if (s8 !== 8'h00 || co8 !== 1'b1 || f8 !== 1'b1) begin
      bad++;
      $display("FAIL ovf_neg: got s=%h co=%b ovf=%b required 00 1 1", s8, co8, f8);
    end
    a8 = 8'h01; b8 = 8'hFF;
    tick();
    iv8 = 1'b0;
    total++;
    if (s8 !== 8'h00 || co8 !== 1'b1 || f8 !== 1'b0) begin
      bad++;
      $display("FAIL ovf_none: got s=%h co=%b ovf=%b required 00 1 0", s8, co8, f8);
    end
    tick();
    total++;
    if (f8 !== 1'b0) begin
      bad++;
      $display("FAIL ovf_hold: got ovf=%b required 0", f8);
    end
  endtask
`endif

  initial begin
    total = 0; bad = 0;
    rst = 1'b1;
    iv1 = 1'b0; a1 = 1'b0; b1 = 1'b0; ci1 = 1'b0;
    iv4 = 1'b0; a4 = '0;   b4 = '0;   ci4 = 1'b0;
    iv8 = 1'b0; a8 = '0;   b8 = '0;   ci8 = 1'b0;
    #1;
    test_reset();
    test_truth_table();
    test_idle_hold();
    test_carry_wrap();
    test_back_to_back();
`ifdef FULL_ADDER_OVF_EN
    test_ovf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
- Registered, width-parameterised ripple-carry full adder. Computes {cout, sum} = a + b + cin and presents the result one clock after the operands are sampled.
- Default WIDTH=1 gives the classic 1-bit full-adder cell, with the truth table registered.
- Used as a leaf arithmetic primitive inside datapaths, and as a smoke-test block for the simulation flow.

Parameters:
- WIDTH, 1, operand and sum width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock for all state
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operands a/b/cin are valid this cycle
- a  input  WIDTH  addend A, unsigned
- b  input  WIDTH  addend B, unsigned
- cin  input  1  carry-in into bit 0
- out_valid  output  1  sum/cout/zero hold a fresh result
- sum  output  WIDTH  registered (a + b + cin) mod 2^WIDTH
- cout  output  1  registered carry out of bit WIDTH-1
- zero  output  1  registered flag, high when the registered sum is all zeros

Behaviour:
- Reset:
  - One clock and one synchronous, active-high reset: rst is sampled on the rising edge of clk.
  - While rst=1 at a clk edge: sum=0, cout=0, zero=0, out_valid=0.
  - rst has priority over in_valid in the same cycle; the operands presented in that cycle are discarded.
- Adder structure:
  - Combinational ripple-carry chain of WIDTH 1-bit cells.
  - Per-bit equations: s[i] = a[i]^b[i]^c[i]; c[i+1] = a[i]&b[i] | a[i]&cin_i | b[i]&cin_i.
  - Boundary values: c[0] = cin, and cout = c[WIDTH].
  - The chain is built with a generate loop; no "+" operator is used, so the cell structure is explicit.
- Capture:
  - On a clk edge with rst=0 and in_valid=1, register sum, cout and zero = (s == 0), and set out_valid=1.
  - Latency is exactly 1 cycle; throughput is 1 result per cycle; there is no backpressure.
- Idle:
  - On a clk edge with rst=0 and in_valid=0, out_valid goes to 0.
  - sum, cout and zero hold their previous values.
- Arithmetic rules:
  - The full result is WIDTH+1 bits, so {cout, sum} never loses information.
  - Maximum case: all-ones + all-ones + 1 gives sum = all-ones, cout=1.
  - Wrap-around: all-ones + 0 + 1 gives sum=0, cout=1, zero=1.
- X handling: operands with in_valid=0 must not affect any output.
- Back-to-back: consecutive in_valid cycles produce consecutive out_valid cycles, each carrying the result of the preceding cycle's operands.
- Reset mid-stream: an in-flight result is dropped. The first out_valid after reset release appears one cycle after the first in_valid sampled with rst=0.

Optional Feature:
- Macro: FULL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), registered with the other outputs, reset to 0, and held when idle.
  - ovf = c[WIDTH] ^ c[WIDTH-1], i.e. two's-complement signed overflow.
  - For WIDTH=1, c[WIDTH-1] is cin.
- Undefined: the ovf port and its logic are absent, and all other behaviour is identical.

Test Plan:
- Exhaustive truth table, WIDTH=1: drive {a,b,cin} = 0..7 with in_valid=1, one vector per cycle. Required (sum,cout) one cycle later, in order: (0,0) (1,0) (1,0) (0,1) (1,0) (0,1) (0,1) (1,1).
- Reset: load a=1, b=1, cin=1, then assert rst=1 with in_valid=1 for one edge. Required: sum=0, cout=0, zero=0, out_valid=0; the first output after release comes from the next sampled operands.
- Idle hold, WIDTH=8: a=0x12, b=0x34, cin=0, then in_valid=0 for 3 cycles. Required: sum=0x46 and cout=0 throughout; out_valid=1 for one cycle, then 0.
- Carry/wrap, WIDTH=8:
  - a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1, zero=1.
  - a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1, zero=0.
- Back-to-back, WIDTH=4: 4 consecutive vectors (3+4+0, 15+1+0, 7+8+1, 0+0+0). Required results in order: 7/0, 0/1, 0/1, 0/0 (sum/cout); zero high on the 2nd, 3rd and 4th results.
- FULL_ADDER_OVF_EN, WIDTH=8:
  - a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1.
  - a=0x80, b=0x80, cin=0 -> sum=0x00, cout=1, ovf=1.
  - a=0x01, b=0xFF, cin=0 -> ovf=0.
